dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters.

---
 rtl/dmem_arbiter_if.sv | 52 +++++
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle between the two data-memory requesters, the arbiter and the data memory.
// slave = arbiter side, master = requesters plus memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    // valid/ready: a request transfers on a cycle where reqN_valid & reqN_ready
    // are both 1. rspN_valid is a one-cycle pulse with no back-pressure.
    logic              req0_valid;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [1:0]        dbg_state;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        input  mem_rdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        output dbg_state
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        output mem_rdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        input  dbg_state
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: fixed priority to port 0 with a
// starvation guard for port 1. Grant counters enabled by macro DMEM_ARB_PERF_EN.
module dmem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_arbiter_if.slave bus,
    output logic [31:0] perf_grant0,
    output logic [31:0] perf_grant1
);
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STV_TOP  = STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic              port_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              pick0, pick1, hs, last_beat;

    assign last_beat = (state_q == ACCESS) && (lat_q == LAT_LAST);

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        starve_d = starve_q;
        pick0    = 1'b0;
        pick1    = 1'b0;
        case (state_q)
            IDLE: begin
                pick1 = bus.req1_valid & (~bus.req0_valid | (starve_q == STV_TOP));
                pick0 = bus.req0_valid & ~pick1;
                if (pick0 | pick1) begin
                    state_d = ACCESS;
                    lat_d   = '0;
                end
                // Count only port-0 wins that actually made port 1 wait.
                if (!bus.req1_valid || pick1) begin
                    starve_d = '0;
                end else if (pick0 && (starve_q != STV_TOP)) begin
                    starve_d = starve_q + 1'b1;
                end
            end
            ACCESS: begin
                if (lat_q == LAT_LAST) state_d = RESP;
                else                   lat_d   = lat_q + 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign hs = pick0 | pick1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            starve_q <= '0;
            port_q   <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
            if (hs) begin
                port_q  <= pick1;
                write_q <= pick1 ? bus.req1_write : bus.req0_write;
                addr_q  <= pick1 ? bus.req1_addr  : bus.req0_addr;
                wdata_q <= pick1 ? bus.req1_wdata : bus.req0_wdata;
            end
            if (last_beat && !write_q) rdata_q <= bus.mem_rdata;
        end
    end

    // ready is combinational off the inputs, so it is gated to stay 0 while in reset.
    assign bus.req0_ready = rst_n & pick0;
    assign bus.req1_ready = rst_n & pick1;

    assign bus.mem_read   = (state_q == ACCESS) & ~write_q;
    assign bus.mem_write  = (state_q == ACCESS) &  write_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;

    assign bus.rsp0_valid = (state_q == RESP) & ~port_q;
    assign bus.rsp1_valid = (state_q == RESP) &  port_q;
    assign bus.rsp0_rdata = (bus.rsp0_valid && !write_q) ? rdata_q : '0;
    assign bus.rsp1_rdata = (bus.rsp1_valid && !write_q) ? rdata_q : '0;

    assign bus.dbg_state  = state_q;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf0_q, perf1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf0_q <= '0;
            perf1_q <= '0;
        end else begin
            if (pick0 && (perf0_q != 32'hFFFF_FFFF)) perf0_q <= perf0_q + 32'd1;
            if (pick1 && (perf1_q != 32'hFFFF_FFFF)) perf1_q <= perf1_q + 32'd1;
        end
    end

    assign perf_grant0 = perf0_q;
    assign perf_grant1 = perf1_q;
`else
    assign perf_grant0 = 32'd0;
    assign perf_grant1 = 32'd0;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one DUT with MEM_LAT=1 and one with MEM_LAT=3.
module tb_dmem_arbiter;
    logic        clk;
    logic        rst_n;
    logic [31:0] p0a, p1a, p0b, p1b;
    int          checks;
    int          failures;
    logic [0:0]  exp_q[$];

`ifdef DMEM_ARB_PERF_EN
    localparam int PERF_ON = 1;
`else
    localparam int PERF_ON = 0;
`endif

    dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus1 ();
    dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus3 ();

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .perf_grant0(p0a), .perf_grant1(p1a));

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .perf_grant0(p0b), .perf_grant1(p1b));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic idle_inputs();
        bus1.req0_valid = 0; bus1.req0_write = 0; bus1.req0_addr = '0; bus1.req0_wdata = '0;
        bus1.req1_valid = 0; bus1.req1_write = 0; bus1.req1_addr = '0; bus1.req1_wdata = '0;
        bus1.mem_rdata  = '0;
        bus3.req0_valid = 0; bus3.req0_write = 0; bus3.req0_addr = '0; bus3.req0_wdata = '0;
        bus3.req1_valid = 0; bus3.req1_write = 0; bus3.req1_addr = '0; bus3.req1_wdata = '0;
        bus3.mem_rdata  = '0;
    endtask

    task automatic do_access(input bit port, input bit wr, input logic [63:0] addr);
        bit seen;
        seen = 0;
        @(negedge clk);
        if (port) begin
            bus1.req1_valid = 1; bus1.req1_write = wr; bus1.req1_addr = addr; bus1.req1_wdata = addr;
        end else begin
            bus1.req0_valid = 1; bus1.req0_write = wr; bus1.req0_addr = addr; bus1.req0_wdata = addr;
        end
        @(negedge clk);
        bus1.req0_valid = 0;
        bus1.req1_valid = 0;
        for (int i = 0; i < 10; i++) begin
            if ((port ? bus1.rsp1_valid : bus1.rsp0_valid) === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL access_timeout port=%0d got=no_rsp exp=rsp", port);
        end
        @(negedge clk);
    endtask

    // scenarios
    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        bus1.req0_valid = 1;
        bus1.req1_valid = 1;
        @(negedge clk);
        checks++; if (bus1.req0_ready !== 1'b0) begin failures++; $display("FAIL rst_ready0 got=%b exp=0", bus1.req0_ready); end
        checks++; if (bus1.req1_ready !== 1'b0) begin failures++; $display("FAIL rst_ready1 got=%b exp=0", bus1.req1_ready); end
        checks++; if ({bus1.mem_read, bus1.mem_write} !== 2'b00) begin failures++; $display("FAIL rst_mem_rw got=%b exp=00", {bus1.mem_read, bus1.mem_write}); end
        checks++; if (bus1.mem_addr !== 64'h0) begin failures++; $display("FAIL rst_mem_addr got=%0h exp=0", bus1.mem_addr); end
        checks++; if ({bus1.rsp0_valid, bus1.rsp1_valid} !== 2'b00) begin failures++; $display("FAIL rst_rsp got=%b exp=00", {bus1.rsp0_valid, bus1.rsp1_valid}); end
        checks++; if ({p0a, p1a} !== 64'h0) begin failures++; $display("FAIL rst_perf got=%0h exp=0", {p0a, p1a}); end
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_port0_load();
        bus1.mem_rdata = 64'hDEAD;
        bus1.req0_valid = 1; bus1.req0_write = 0; bus1.req0_addr = 64'h10;
        #1;
        checks++; if (bus1.req0_ready !== 1'b1) begin failures++; $display("FAIL t1_ready0 got=%b exp=1", bus1.req0_ready); end
        checks++; if (bus1.req1_ready !== 1'b0) begin failures++; $display("FAIL t1_ready1 got=%b exp=0", bus1.req1_ready); end
        @(negedge clk);
        bus1.req0_valid = 0;
        checks++; if ({bus1.mem_read, bus1.mem_write} !== 2'b10) begin failures++; $display("FAIL t1_mem_rw got=%b exp=10", {bus1.mem_read, bus1.mem_write}); end
        checks++; if (bus1.mem_addr !== 64'h10) begin failures++; $display("FAIL t1_mem_addr got=%0h exp=10", bus1.mem_addr); end
        @(negedge clk);
        checks++; if (bus1.rsp0_valid !== 1'b1) begin failures++; $display("FAIL t1_rsp0_valid got=%b exp=1", bus1.rsp0_valid); end
        checks++; if (bus1.rsp0_rdata !== 64'hDEAD) begin failures++; $display("FAIL t1_rsp0_rdata got=%0h exp=dead", bus1.rsp0_rdata); end
        checks++; if ({bus1.rsp1_valid, bus1.mem_read} !== 2'b00) begin failures++; $display("FAIL t1_idle_side got=%b exp=00", {bus1.rsp1_valid, bus1.mem_read}); end
        @(negedge clk);
        checks++; if (bus1.rsp0_valid !== 1'b0) begin failures++; $display("FAIL t1_rsp0_pulse got=%b exp=0", bus1.rsp0_valid); end
    endtask

    task automatic test_port1_store();
        bus1.mem_rdata = 64'hBEEF;
        bus1.req1_valid = 1; bus1.req1_write = 1; bus1.req1_addr = 64'h20; bus1.req1_wdata = 64'h55;
        #1;
        checks++; if ({bus1.req1_ready, bus1.req0_ready} !== 2'b10) begin failures++; $display("FAIL t2_ready got=%b exp=10", {bus1.req1_ready, bus1.req0_ready}); end
        @(negedge clk);
        bus1.req1_valid = 0;
        checks++; if ({bus1.mem_read, bus1.mem_write} !== 2'b01) begin failures++; $display("FAIL t2_mem_rw got=%b exp=01", {bus1.mem_read, bus1.mem_write}); end
        checks++; if (bus1.mem_addr !== 64'h20) begin failures++; $display("FAIL t2_mem_addr got=%0h exp=20", bus1.mem_addr); end
        checks++; if (bus1.mem_wdata !== 64'h55) begin failures++; $display("FAIL t2_mem_wdata got=%0h exp=55", bus1.mem_wdata); end
        @(negedge clk);
        checks++; if (bus1.rsp1_valid !== 1'b1) begin failures++; $display("FAIL t2_rsp1_valid got=%b exp=1", bus1.rsp1_valid); end
        checks++; if (bus1.rsp1_rdata !== 64'h0) begin failures++; $display("FAIL t2_rsp1_rdata got=%0h exp=0", bus1.rsp1_rdata); end
        checks++; if (bus1.mem_write !== 1'b0) begin failures++; $display("FAIL t2_write_len got=%b exp=0", bus1.mem_write); end
        checks++; if (bus1.mem_addr !== 64'h20) begin failures++; $display("FAIL t2_addr_hold got=%0h exp=20", bus1.mem_addr); end
        @(negedge clk);
    endtask

    task automatic test_starvation();
        int got;
        logic [0:0] g, e;
        got = 0;
        exp_q = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bus1.req0_valid = 1; bus1.req0_write = 0; bus1.req0_addr = 64'h100;
        bus1.req1_valid = 1; bus1.req1_write = 0; bus1.req1_addr = 64'h200;
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            #1;
            if (bus1.req0_ready === 1'b1 || bus1.req1_ready === 1'b1) begin
                g = bus1.req1_ready;
                e = exp_q.pop_front();
                checks++;
                if (g !== e) begin failures++; $display("FAIL t3_grant%0d got=%0d exp=%0d", got, g, e); end
                got++;
            end
            @(negedge clk);
        end
        checks++;
        if (got != 10) begin failures++; $display("FAIL t3_grant_count got=%0d exp=10", got); end
        bus1.req0_valid = 0;
        bus1.req1_valid = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        int pulses;
        pulses = 0;
        bus1.mem_rdata = 64'h7777;
        bus1.req0_valid = 1; bus1.req0_write = 0; bus1.req0_addr = 64'h30;
        @(negedge clk);
        bus1.req0_valid = 0;
        checks++; if (bus1.mem_read !== 1'b1) begin failures++; $display("FAIL t4_read_before got=%b exp=1", bus1.mem_read); end
        #2 rst_n = 0;
        #1;
        checks++; if (bus1.mem_read !== 1'b0) begin failures++; $display("FAIL t4_read_async got=%b exp=0", bus1.mem_read); end
        @(negedge clk);
        rst_n = 1;
        repeat (5) begin
            @(negedge clk);
            if (bus1.rsp0_valid === 1'b1 || bus1.rsp1_valid === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL t4_stale_rsp got=%0d exp=0", pulses); end
        bus1.mem_rdata = 64'h1234;
        bus1.req0_valid = 1; bus1.req0_write = 0; bus1.req0_addr = 64'h40;
        #1;
        checks++; if (bus1.req0_ready !== 1'b1) begin failures++; $display("FAIL t4_ready0 got=%b exp=1", bus1.req0_ready); end
        @(negedge clk);
        bus1.req0_valid = 0;
        @(negedge clk);
        checks++; if ({bus1.rsp0_valid, bus1.rsp0_rdata} !== {1'b1, 64'h1234}) begin failures++; $display("FAIL t4_rsp0 got=%b/%0h exp=1/1234", bus1.rsp0_valid, bus1.rsp0_rdata); end
        @(negedge clk);
    endtask

    task automatic test_mem_lat3();
        int read_cnt, rsp_at;
        logic [63:0] rd;
        read_cnt = 0; rsp_at = -1; rd = '0;
        bus3.mem_rdata = 64'hCAFE;
        bus3.req0_valid = 1; bus3.req0_write = 0; bus3.req0_addr = 64'h50;
        #1;
        checks++; if (bus3.req0_ready !== 1'b1) begin failures++; $display("FAIL t5_ready0 got=%b exp=1", bus3.req0_ready); end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            bus3.req0_valid = 0;
            if (bus3.mem_read === 1'b1) read_cnt++;
            if (bus3.rsp0_valid === 1'b1) begin rsp_at = k; rd = bus3.rsp0_rdata; end
        end
        checks++; if (read_cnt != 3) begin failures++; $display("FAIL t5_read_cycles got=%0d exp=3", read_cnt); end
        checks++; if (rsp_at != 4) begin failures++; $display("FAIL t5_rsp_latency got=%0d exp=4", rsp_at); end
        checks++; if (rd !== 64'hCAFE) begin failures++; $display("FAIL t5_rdata got=%0h exp=cafe", rd); end
    endtask

    task automatic test_perf();
        logic [31:0] e0, e1;
        e0 = (PERF_ON != 0) ? 32'd5 : 32'd0;
        e1 = (PERF_ON != 0) ? 32'd2 : 32'd0;
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        do_access(1'b0, 1'b0, 64'h60);
        do_access(1'b1, 1'b1, 64'h68);
        do_access(1'b0, 1'b1, 64'h70);
        do_access(1'b0, 1'b0, 64'h78);
        do_access(1'b1, 1'b0, 64'h80);
        do_access(1'b0, 1'b0, 64'h88);
        do_access(1'b0, 1'b1, 64'h90);
        checks++; if (p0a !== e0) begin failures++; $display("FAIL t6_perf0 got=%0d exp=%0d", p0a, e0); end
        checks++; if (p1a !== e1) begin failures++; $display("FAIL t6_perf1 got=%0d exp=%0d", p1a, e1); end
        checks++; if ({p0b, p1b} !== 64'h0) begin failures++; $display("FAIL t6_perf_idle got=%0h exp=0", {p0b, p1b}); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_port0_load();
        test_port1_store();
        test_starvation();
        test_reset_mid_access();
        test_mem_lat3();
        test_perf();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
